// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU/DMA memory bus arbiter.
// ROM write protection is enabled with the ARB_ROM_PROTECT_EN macro.
package mem_bus_pkg;
  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;

  // System memory map: ROM window is address[18:13] == ROM_BASE_HI
  localparam logic [5:0]  ROM_BASE_HI   = 6'd4;
  localparam logic [18:0] RAM_BASE      = 19'h0B000;
  localparam logic [18:0] UART_ADDR     = 19'h3F201;
  localparam logic [18:0] SIM_STOP_ADDR = 19'h3F900;

  localparam logic LG_C = 1'b0;
  localparam logic LG_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  function automatic logic in_rom(input logic [5:0] addr_hi);
    return addr_hi == ROM_BASE_HI;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-input picker: round-robin on ties, or fixed CPU priority when
// CPU_PRIORITY is set.
module rr_arb2
  import mem_bus_pkg::*;
#(
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic eff_c,
  input  logic eff_d,
  input  logic last_grant,
  output logic gnt_c,
  output logic gnt_d
);
  logic c_wins_tie;

  assign c_wins_tie = CPU_PRIORITY | (last_grant == LG_D);
  assign gnt_c      = eff_c & (~eff_d | c_wins_tie);
  assign gnt_d      = eff_d & ~gnt_c;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-cycle req/ack arbiter sharing the memory bus between CPU (C) and DMA (D).
// Define ARB_ROM_PROTECT_EN to suppress writes into the ROM window and add rom_wr_err.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_ROM_PROTECT_EN
  output logic              rom_wr_err,
`endif
  output logic              busy
);
  arb_state_t        state, state_nxt;
  logic              last_grant;
  logic              eff_c, eff_d, gnt_c, gnt_d;
  logic              sel_we, wr_block;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A port's ack cycle masks its still-high req so it is not granted twice
  assign eff_c = c_req & ~c_ack;
  assign eff_d = d_req & ~d_ack;

  rr_arb2 #(.CPU_PRIORITY(CPU_PRIORITY)) u_arb (
    .eff_c     (eff_c),
    .eff_d     (eff_d),
    .last_grant(last_grant),
    .gnt_c     (gnt_c),
    .gnt_d     (gnt_d)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_c)      state_nxt = GNT_C;
        else if (gnt_d) state_nxt = GNT_D;
      end
      GNT_C, GNT_D: state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    busy      = 1'b0;
    case (state)
      GNT_C: begin
        sel_addr  = c_addr;
        sel_wdata = c_wdata;
        sel_we    = c_we;
        busy      = 1'b1;
      end
      GNT_D: begin
        sel_addr  = d_addr;
        sel_wdata = d_wdata;
        sel_we    = d_we;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARB_ROM_PROTECT_EN
  assign wr_block = sel_we & in_rom(sel_addr[ADDR_W-1 -: 6]);
`else
  assign wr_block = 1'b0;
`endif

  assign mem_address  = sel_addr;
  assign mem_wdata    = sel_wdata;
  assign mem_write_en = sel_we & ~wr_block;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= LG_D;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nxt;
      c_ack <= (state == GNT_C);
      d_ack <= (state == GNT_D);
      if (state == GNT_C) begin
        last_grant <= LG_C;
        if (!c_we) c_rdata <= mem_rdata;
      end
      if (state == GNT_D) begin
        last_grant <= LG_D;
        if (!d_we) d_rdata <= mem_rdata;
      end
    end
  end

`ifdef ARB_ROM_PROTECT_EN
  // Error pulse lines up with the ack of the blocked write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rom_wr_err <= 1'b0;
    else        rom_wr_err <= wr_block;
  end
`endif
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single-port 19-bit system memory/MMIO bus between two requesters: the CPU6 core (port C) and a DMA/loader engine (port D).
- Sits between both masters and the Memory block.
- Memory read data is combinational; memory writes commit on posedge clock.
- Each access is a req/ack transaction of exactly one bus cycle.

Parameters:
ADDR_W, 19, bus address width
DATA_W, 8, bus data width
CPU_PRIORITY, 0, 0 = round-robin between C and D; 1 = C always wins ties

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low (asserted when 0)
c_req  input  1  CPU request, held high until c_ack seen
c_we  input  1  CPU write (1) / read (0), stable while c_req
c_addr  input  ADDR_W  CPU address, stable while c_req
c_wdata  input  DATA_W  CPU write data
c_rdata  output  DATA_W  CPU read data, valid when c_ack
c_ack  output  1  one-cycle completion pulse
d_req, d_we, d_addr, d_wdata, d_rdata, d_ack  same directions/widths/meaning as the c_* ports, for DMA
mem_address  output  ADDR_W  to Memory address
mem_write_en  output  1  to Memory write enable
mem_wdata  output  DATA_W  to Memory data_in
mem_rdata  input  DATA_W  from Memory data_out
busy  output  1  high while a grant state is active

Behaviour:
- FSM states: IDLE, GNT_C, GNT_D. Also holds a registered last_grant bit (C/D).
- Reset (async, reset==0):
  - state = IDLE, last_grant = D, so C wins the first tie.
  - All outputs 0: mem_address, mem_write_en, mem_wdata, acks, rdata, busy.
  - An in-flight access is abandoned. No ack is issued and no write commits.
- IDLE arbitration, using masked requests:
  - eff_c = c_req & ~c_ack; eff_d = d_req & ~d_ack.
  - A requester sees its ack in the cycle it must drop req. Masking prevents a double grant.
  - Only eff_c set: go to GNT_C. Only eff_d set: go to GNT_D. Neither: stay in IDLE.
  - Both set, CPU_PRIORITY=1: go to GNT_C.
  - Both set, CPU_PRIORITY=0: grant the port that is not last_grant.
- Grant state (GNT_x), lasts exactly one cycle:
  - mem_address, mem_wdata and mem_write_en are driven combinationally from port x. mem_write_en = x_we.
  - Outside grant states, mem_write_en = 0 and address/wdata = 0.
  - busy = 1.
  - At the closing edge: x_rdata <= mem_rdata (reads only; writes leave x_rdata unchanged), x_ack <= 1, last_grant <= x, state <= IDLE.
- Acks: registered pulses lasting exactly one cycle. c_ack and d_ack are never high together.
- Latency: req sampled at edge N, bus driven in cycle N+1, ack high in cycle N+2.
  - Minimum spacing for one port: 3 cycles per transaction.
  - Two contending ports interleave, one grant every 2 cycles.
- x_rdata holds its value until the next read completes on that port.
- A req dropped before its grant is simply not served.
- Changing addr/we/wdata while req is high is illegal and is not checked.
- Round-robin fairness: with both ports continuously requesting, neither waits more than one foreign transaction.

Optional Feature:
ARB_ROM_PROTECT_EN
- Defined:
  - A granted write whose address[18:13]==4 (ROM window 0x08000-0x09FFF) is suppressed: mem_write_en stays 0.
  - The port still receives its ack.
  - Extra output port rom_wr_err (1 bit, reset 0) pulses for one cycle, coincident with that ack.
- Undefined: no rom_wr_err port. Every write is passed to the bus unchanged.

Decomposition:
- Package mem_bus_pkg holds:
  - the state typedef (IDLE/GNT_C/GNT_D)
  - ADDR_W/DATA_W defaults
  - ROM_BASE_HI = 6'd4 and the RAM/MMIO region constants (RAM 0x0B000, UART 0x3F201, sim-stop 0x3F900)
- One natural sub-module: rr_arb2, a 2-input round-robin/priority picker from (eff_c, eff_d, last_grant, CPU_PRIORITY) to the grant.
- The FSM, bus mux and ack/rdata registers stay in the top.

Test Plan:
1. Reset pulse low at t=50 ns for 200 ns -> all outputs 0 and busy=0 during and after reset. First CPU read of 0x3FD00 returns c_rdata=0x71, c_ack at cycle N+2.
2. CPU write 0x5A to 0x0B010, then CPU read 0x0B010 -> mem_write_en high for exactly one cycle; read returns 0x5A; d_ack stays 0.
3. c_req and d_req asserted in the same cycle, each re-requesting immediately, CPU_PRIORITY=0 -> grant order C,D,C,D. Acks alternate every 2 cycles, never coincident.
4. Same stimulus with CPU_PRIORITY=1 and c_req held continuously -> C is granted every IDLE; D is served only in cycles where eff_c=0.
5. Reset asserted during GNT_D with a DMA write to 0x0B020 -> no ack and no memory write; location still 0x00 after reset release.
6. With ARB_ROM_PROTECT_EN, CPU writes 0xFF to 0x08001 -> c_ack=1, rom_wr_err=1 in the same cycle, mem_write_en never 1; read-back still equals the preloaded ROM byte.
